// File: rtl/mem_load_unit_pkg.sv
// mem_load_unit_pkg: shared width codes, FSM states and alignment check for the load path
package mem_load_unit_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;
    localparam logic [1:0] WIDTH_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        return (width == WIDTH_WORD && off != 2'b00) ||
               (width == WIDTH_HALF && off[0]) ||
               (width == WIDTH_ILL);
    endfunction

endpackage

// File: rtl/mem_load_unit_extract.sv
// mem_load_unit_extract: selects the addressed lane of a read word and sign/zero-extends it
module mem_load_unit_extract
    import mem_load_unit_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic        i_signed,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_byte = i_off[1] ? (i_off[0] ? i_rdata[31:24] : i_rdata[23:16])
                             : (i_off[0] ? i_rdata[15:8]  : i_rdata[7:0]);
    assign o_data = (i_width == WIDTH_HALF) ? {{16{i_signed & w_half[15]}}, w_half} :
                    (i_width == WIDTH_BYTE) ? {{24{i_signed & w_byte[7]}}, w_byte} :
                    i_rdata;

endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: issues one aligned bus read per load, waits for ack or timeout, returns extended data
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ld_valid,
    input  logic [1:0]  i_ld_width,
    input  logic        i_ld_signed,
    input  logic [31:0] i_ld_addr,
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_ld_busy,
    output logic        o_ld_done,
    output logic [31:0] o_ld_data,
    output logic        o_ld_adel,
    output logic        o_ld_buserr
);

    state_t             r_state, w_state;
    logic               r_bus_req, w_bus_req;
    logic [31:0]        r_bus_addr, w_bus_addr;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic [31:0]        r_data, w_data;
    logic               r_adel, w_adel;
    logic               r_buserr, w_buserr;
    logic [1:0]         r_width, w_width;
    logic               r_signed, w_signed;
    logic [1:0]         r_off, w_off;
    logic [CNT_W-1:0]   r_timer, w_timer;
    logic [31:0]        w_ext;

    mem_load_unit_extract u_extract (
        .i_width  (r_width),
        .i_signed (r_signed),
        .i_off    (r_off),
        .i_rdata  (i_bus_rdata),
        .o_data   (w_ext)
    );

    // state and every output come straight from flops
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_bus_req  <= 1'b0;
            r_bus_addr <= 32'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= 32'h0;
            r_adel     <= 1'b0;
            r_buserr   <= 1'b0;
            r_width    <= WIDTH_WORD;
            r_signed   <= 1'b0;
            r_off      <= 2'b00;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state;
            r_bus_req  <= w_bus_req;
            r_bus_addr <= w_bus_addr;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_data     <= w_data;
            r_adel     <= w_adel;
            r_buserr   <= w_buserr;
            r_width    <= w_width;
            r_signed   <= w_signed;
            r_off      <= w_off;
            r_timer    <= w_timer;
        end
    end

    // next state; completion flags default low so they last only the DONE cycle
    always_comb begin
        w_state    = r_state;
        w_bus_req  = r_bus_req;
        w_bus_addr = r_bus_addr;
        w_done     = 1'b0;
        w_data     = r_data;
        w_adel     = 1'b0;
        w_buserr   = 1'b0;
        w_width    = r_width;
        w_signed   = r_signed;
        w_off      = r_off;
        w_timer    = r_timer;
        case (r_state)
            S_IDLE: begin
                if (i_ld_valid) begin
                    if (is_misaligned(i_ld_width, i_ld_addr[1:0])) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                        w_adel  = 1'b1;
                    end else begin
                        w_state    = S_WAIT;
                        w_bus_req  = 1'b1;
                        w_bus_addr = {i_ld_addr[31:2], 2'b00};
                        w_width    = i_ld_width;
                        w_signed   = i_ld_signed;
                        w_off      = i_ld_addr[1:0];
                        w_timer    = '0;
                    end
                end
            end
            S_WAIT: begin
                if (i_bus_ack) begin
                    w_state   = S_DONE;
                    w_bus_req = 1'b0;
                    w_done    = 1'b1;
                    w_data    = w_ext;
                end else if (r_timer == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state   = S_DONE;
                    w_bus_req = 1'b0;
                    w_done    = 1'b1;
                    w_buserr  = 1'b1;
                    w_data    = 32'h0;
                end else begin
                    w_timer = r_timer + CNT_W'(1);
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        w_busy = (w_state != S_IDLE);
    end

    assign o_bus_req   = r_bus_req;
    assign o_bus_addr  = r_bus_addr;
    assign o_ld_busy   = r_busy;
    assign o_ld_done   = r_done;
    assign o_ld_data   = r_data;
    assign o_ld_adel   = r_adel;
    assign o_ld_buserr = r_buserr;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed checks of the load unit with a 4-cycle bus timeout
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [1:0]  ld_width = 2'b00;
    logic        ld_signed = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        ld_busy, ld_done, ld_adel, ld_buserr;
    logic [31:0] ld_data;

    int vectors = 0;
    int miscompares = 0;

    mem_load_unit #(.TIMEOUT_CYCLES(4), .CNT_W(2)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_ld_valid  (ld_valid),
        .i_ld_width  (ld_width),
        .i_ld_signed (ld_signed),
        .i_ld_addr   (ld_addr),
        .o_bus_req   (bus_req),
        .o_bus_addr  (bus_addr),
        .i_bus_ack   (bus_ack),
        .i_bus_rdata (bus_rdata),
        .o_ld_busy   (ld_busy),
        .o_ld_done   (ld_done),
        .o_ld_data   (ld_data),
        .o_ld_adel   (ld_adel),
        .o_ld_buserr (ld_buserr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] w, input logic s, input logic [31:0] a);
        ld_valid = 1'b1; ld_width = w; ld_signed = s; ld_addr = a;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic ack_after(input int nwait, input logic [31:0] d);
        repeat (nwait) tick();
        bus_ack = 1'b1; bus_rdata = d;
        tick();
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({bus_req, ld_busy, ld_done, ld_adel, ld_buserr} !== 5'b0 || bus_addr !== 32'h0 || ld_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: req=%b busy=%b done=%b adel=%b buserr=%b addr=%h data=%h, required all zero",
                     bus_req, ld_busy, ld_done, ld_adel, ld_buserr, bus_addr, ld_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        vectors++;
        if (ld_done !== 1'b0 || ld_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ack: done=%b busy=%b, required 0 0", ld_done, ld_busy);
        end
    endtask

    task automatic test_word();
        int req_cycles = 0;
        start(2'b00, 1'b0, 32'h0000_1000);
        vectors++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_1000 || ld_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL lw_issue: req=%b addr=%h busy=%b, required 1 00001000 1", bus_req, bus_addr, ld_busy);
        end
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_addr = 32'h0000_2000;
            req_cycles += (bus_req && ld_busy && !ld_done) ? 1 : 0;
            tick();
        end
        ld_valid = 1'b0;
        req_cycles += (bus_req && ld_busy && bus_addr == 32'h0000_1000) ? 1 : 0;
        vectors++;
        if (req_cycles !== 3) begin
            miscompares++;
            $display("FAIL lw_hold: req/busy cycles=%0d, required 3", req_cycles);
        end
        ack_after(0, 32'hDEAD_BEEF);
        vectors++;
        if (ld_done !== 1'b1 || ld_data !== 32'hDEAD_BEEF || ld_busy !== 1'b1 || bus_req !== 1'b0 || ld_adel !== 1'b0 || ld_buserr !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_done: done=%b data=%h busy=%b req=%b adel=%b buserr=%b, required 1 deadbeef 1 0 0 0",
                     ld_done, ld_data, ld_busy, bus_req, ld_adel, ld_buserr);
        end
        tick();
        vectors++;
        if (ld_done !== 1'b0 || ld_busy !== 1'b0 || ld_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL lw_after: done=%b busy=%b data=%h, required 0 0 deadbeef", ld_done, ld_busy, ld_data);
        end
    endtask

    task automatic test_extract();
        logic [1:0]  tw [10] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b01};
        logic        ts [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ta [10] = '{32'h1003, 32'h1002, 32'h1002, 32'h1000, 32'h1000,
                                 32'h1001, 32'h1003, 32'h1000, 32'h2000, 32'h1002};
        logic [31:0] td [10] = '{32'h80123456, 32'h80123456, 32'h80017FFF, 32'h80017FFF, 32'h80123456,
                                 32'h80123456, 32'h80123456, 32'h80017FFF, 32'h80000000, 32'h80017FFF};
        logic [31:0] te [10] = '{32'hFFFFFF80, 32'h00000012, 32'hFFFF8001, 32'h00007FFF, 32'h00000056,
                                 32'h00000034, 32'h00000080, 32'h00007FFF, 32'h80000000, 32'h00008001};
        for (int i = 0; i < 10; i++) begin
            start(tw[i], ts[i], ta[i]);
            vectors++;
            if (bus_addr !== {ta[i][31:2], 2'b00}) begin
                miscompares++;
                $display("FAIL extract_addr[%0d]: bus_addr=%h, required %h", i, bus_addr, {ta[i][31:2], 2'b00});
            end
            ack_after(i % 3, td[i]);
            vectors++;
            if (ld_done !== 1'b1 || ld_data !== te[i] || ld_buserr !== 1'b0) begin
                miscompares++;
                $display("FAIL extract[%0d]: done=%b data=%h buserr=%b, required 1 %h 0", i, ld_done, ld_data, ld_buserr, te[i]);
            end
            tick();
        end
    endtask

    task automatic test_adel();
        logic [1:0]  tw [3] = '{2'b00, 2'b01, 2'b11};
        logic [31:0] ta [3] = '{32'h1002, 32'h1001, 32'h1000};
        for (int i = 0; i < 3; i++) begin
            start(tw[i], 1'b0, ta[i]);
            vectors++;
            if (ld_done !== 1'b1 || ld_adel !== 1'b1 || bus_req !== 1'b0 || ld_buserr !== 1'b0 || ld_data !== 32'h00008001) begin
                miscompares++;
                $display("FAIL adel[%0d]: done=%b adel=%b req=%b buserr=%b data=%h, required 1 1 0 0 00008001",
                         i, ld_done, ld_adel, bus_req, ld_buserr, ld_data);
            end
            tick();
            vectors++;
            if (ld_done !== 1'b0 || ld_adel !== 1'b0 || bus_req !== 1'b0 || ld_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL adel_clear[%0d]: done=%b adel=%b req=%b busy=%b, required 0 0 0 0", i, ld_done, ld_adel, bus_req, ld_busy);
            end
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int guard = 0;
        start(2'b00, 1'b0, 32'h0000_3000);
        while (!ld_done && guard < 20) begin
            req_cycles += bus_req ? 1 : 0;
            tick();
            guard++;
        end
        vectors++;
        if (req_cycles !== 4 || ld_done !== 1'b1 || ld_buserr !== 1'b1 || ld_data !== 32'h0 || bus_req !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: req_cycles=%0d done=%b buserr=%b data=%h req=%b, required 4 1 1 00000000 0",
                     req_cycles, ld_done, ld_buserr, ld_data, bus_req);
        end
        tick();
        vectors++;
        if (ld_buserr !== 1'b0 || ld_done !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: buserr=%b done=%b, required 0 0", ld_buserr, ld_done);
        end
        start(2'b00, 1'b0, 32'h0000_3004);
        ack_after(3, 32'h1234_5678);
        vectors++;
        if (ld_done !== 1'b1 || ld_buserr !== 1'b0 || ld_data !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL expiry_ack: done=%b buserr=%b data=%h, required 1 0 12345678", ld_done, ld_buserr, ld_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        start(2'b10, 1'b0, 32'h0000_4001);
        ld_valid = 1'b1; ld_width = 2'b00; ld_addr = 32'h0000_5000;
        ack_after(0, 32'hA5A5_C3C3);
        vectors++;
        if (ld_done !== 1'b1 || ld_data !== 32'h0000_00C3) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b data=%h, required 1 000000c3", ld_done, ld_data);
        end
        tick();
        vectors++;
        if (bus_req !== 1'b0 || ld_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done_ignore: req=%b busy=%b, required 0 0", bus_req, ld_busy);
        end
        tick();
        ld_valid = 1'b0;
        vectors++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_5000) begin
            miscompares++;
            $display("FAIL b2b_second: req=%b addr=%h, required 1 00005000", bus_req, bus_addr);
        end
        ack_after(1, 32'h0BAD_F00D);
        vectors++;
        if (ld_done !== 1'b1 || ld_data !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL b2b_second_data: done=%b data=%h, required 1 0badf00d", ld_done, ld_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int dones = 0;
        start(2'b00, 1'b0, 32'h0000_6000);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus_req !== 1'b0 || ld_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: req=%b busy=%b, required 0 0", bus_req, ld_busy);
        end
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            dones += ld_done ? 1 : 0;
        end
        bus_ack = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            dones += ld_done ? 1 : 0;
        end
        vectors++;
        if (dones !== 0 || ld_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_no_done: done pulses=%0d data=%h, required 0 00000000", dones, ld_data);
        end
        start(2'b01, 1'b1, 32'h0000_7002);
        ack_after(0, 32'hFFFE_0001);
        vectors++;
        if (ld_done !== 1'b1 || ld_data !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL reset_recover: done=%b data=%h, required 1 fffffffe", ld_done, ld_data);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_extract();
        test_adel();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
